// File: rtl/msrv32_decode_stage.sv
// rtl/msrv32_decode_stage.sv - RV32I/RV64I(+M) instruction decoder with registered bundle and 2-entry skid buffer
module msrv32_decode_stage #(
    parameter int XLEN      = 32,
    parameter int SUPPORT_M = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 ms_riscv32_mp_clk_in,
    input  logic                 ms_riscv32_mp_rst_in,
    input  logic                 flush_in,
    input  logic                 instr_valid_in,
    output logic                 instr_ready_out,
    input  logic [31:0]          instr_in,
    input  logic [2:0]           iadder_lsb_in,
    output logic                 dec_valid_out,
    input  logic                 dec_ready_in,
    input  logic                 trap_taken_in,
    output logic [2:0]           wb_mux_sel_out,
    output logic [2:0]           imm_type_out,
    output logic [3:0]           alu_opcode_out,
    output logic                 alu_src_out,
    output logic                 iadder_src_out,
    output logic [1:0]           load_size_out,
    output logic                 load_unsigned_out,
    output logic                 rf_wr_en_out,
    output logic                 csr_wr_en_out,
    output logic [2:0]           csr_op_out,
    output logic                 is_muldiv_out,
    output logic                 mem_wr_req_out,
    output logic                 illegal_instr_out,
    output logic                 misaligned_load_out,
    output logic                 misaligned_store_out,
    output logic [CNT_WIDTH-1:0] decode_count_out
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic       HAS_M      = (SUPPORT_M != 0);
    localparam logic       IS_RV32    = (XLEN == 32);

    typedef struct packed {
        logic [2:0] wb_mux_sel;
        logic [2:0] imm_type;
        logic [3:0] alu_opcode;
        logic       alu_src;
        logic       iadder_src;
        logic [1:0] load_size;
        logic       load_unsigned;
        logic       rf_wr_en;
        logic       csr_wr_en;
        logic [2:0] csr_op;
        logic       is_muldiv;
        logic       store_ok;
        logic       illegal;
        logic       mis_load;
        logic       mis_store;
    } bundle_t;

    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} state_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;
    logic       misaligned;
    logic       unused_bits;
    bundle_t    dec;

    assign opcode      = instr_in[6:0];
    assign funct3      = instr_in[14:12];
    assign funct7      = instr_in[31:25];
    assign unused_bits = ^{instr_in[24:15], instr_in[11:7]};

    // Access size comes from funct3[1:0]: byte, half, word, double.
    always_comb begin
        case (funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = iadder_lsb_in[0];
            2'b10:   misaligned = |iadder_lsb_in[1:0];
            default: misaligned = |iadder_lsb_in;
        endcase
    end

    always_comb begin
        dec            = '0;
        legal          = 1'b1;
        dec.alu_opcode = {1'b0, funct3};
        case (opcode)
            OPC_LOAD: begin
                dec.wb_mux_sel    = 3'b001;
                dec.imm_type      = 3'b001;
                dec.iadder_src    = 1'b1;
                dec.load_size     = funct3[1:0];
                dec.load_unsigned = funct3[2];
                dec.rf_wr_en      = 1'b1;
                legal = !((funct3 == 3'b111) ||
                          (IS_RV32 && (funct3 == 3'b011 || funct3 == 3'b110)));
            end
            OPC_STORE: begin
                dec.imm_type   = 3'b010;
                dec.iadder_src = 1'b1;
                legal = !(funct3[2] || (IS_RV32 && funct3 == 3'b011));
            end
            OPC_OPIMM: begin
                dec.imm_type      = 3'b001;
                dec.rf_wr_en      = 1'b1;
                dec.alu_opcode[3] = (funct3 == 3'b101) & instr_in[30];
            end
            OPC_OP: begin
                dec.alu_src  = 1'b1;
                dec.rf_wr_en = 1'b1;
                if (HAS_M && funct7 == 7'b0000001) begin
                    dec.is_muldiv = 1'b1;
                end else begin
                    dec.alu_opcode[3] = instr_in[30];
                end
                legal = (funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) ||
                        (funct7 == 7'b0000001 && HAS_M);
            end
            OPC_LUI: begin
                dec.wb_mux_sel = 3'b010;
                dec.imm_type   = 3'b100;
                dec.rf_wr_en   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.wb_mux_sel = 3'b011;
                dec.imm_type   = 3'b100;
                dec.rf_wr_en   = 1'b1;
            end
            OPC_JAL: begin
                dec.wb_mux_sel = 3'b101;
                dec.imm_type   = 3'b101;
                dec.rf_wr_en   = 1'b1;
            end
            OPC_JALR: begin
                dec.wb_mux_sel = 3'b101;
                dec.imm_type   = 3'b001;
                dec.iadder_src = 1'b1;
                dec.rf_wr_en   = 1'b1;
            end
            OPC_BRANCH: begin
                // Branches compare rs1 against rs2.
                dec.imm_type = 3'b011;
                dec.alu_src  = 1'b1;
                legal = !(funct3 == 3'b010 || funct3 == 3'b011);
            end
            OPC_SYSTEM: begin
                dec.wb_mux_sel = 3'b100;
                dec.imm_type   = 3'b110;
                dec.csr_op     = funct3;
                dec.csr_wr_en  = (funct3 != 3'b000);
                dec.rf_wr_en   = (funct3 != 3'b000);
                legal = (funct3 != 3'b100);
            end
            default: legal = 1'b0;
        endcase
        dec.mis_load  = (opcode == OPC_LOAD) & misaligned;
        dec.mis_store = (opcode == OPC_STORE) & misaligned;
        dec.store_ok  = (opcode == OPC_STORE) & legal & ~misaligned;
        dec.illegal   = ~legal;
        if (!legal) begin
            dec.rf_wr_en  = 1'b0;
            dec.csr_wr_en = 1'b0;
        end
    end

    state_t               state;
    state_t               next_state;
    logic                 ready_q;
    logic                 accept;
    logic                 xfer;
    bundle_t              out_q;
    bundle_t              skid_q;
    bundle_t              shown;
    logic [CNT_WIDTH-1:0] cnt_q;

    assign accept = instr_valid_in & ready_q;
    assign xfer   = dec_valid_out & dec_ready_in;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != ST_TWO);
        end
    end

    always_comb begin
        next_state = state;
        if (flush_in) begin
            next_state = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) next_state = ST_ONE;
                ST_ONE: begin
                    if (accept && !xfer) next_state = ST_TWO;
                    else if (!accept && xfer) next_state = ST_EMPTY;
                end
                ST_TWO:   if (xfer) next_state = ST_ONE;
                default:  next_state = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        dec_valid_out        = (state != ST_EMPTY);
        shown                = dec_valid_out ? out_q : '0;
        wb_mux_sel_out       = shown.wb_mux_sel;
        imm_type_out         = shown.imm_type;
        alu_opcode_out       = shown.alu_opcode;
        alu_src_out          = shown.alu_src;
        iadder_src_out       = shown.iadder_src;
        load_size_out        = shown.load_size;
        load_unsigned_out    = shown.load_unsigned;
        rf_wr_en_out         = shown.rf_wr_en;
        csr_wr_en_out        = shown.csr_wr_en;
        csr_op_out           = shown.csr_op;
        is_muldiv_out        = shown.is_muldiv;
        mem_wr_req_out       = shown.store_ok & ~trap_taken_in;
        illegal_instr_out    = shown.illegal;
        misaligned_load_out  = shown.mis_load;
        misaligned_store_out = shown.mis_store;
    end

    // Payload registers need no reset: they are masked whenever their entry is invalid.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (state == ST_TWO && xfer) begin
            out_q <= skid_q;
        end else if (accept && (state == ST_EMPTY || xfer)) begin
            out_q <= dec;
        end
        if (accept && state == ST_ONE && !xfer) begin
            skid_q <= dec;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            cnt_q <= '0;
        end else if (xfer && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign instr_ready_out  = ready_q;
    assign decode_count_out = cnt_q;
endmodule

// File: tb/tb_msrv32_decode_stage.sv
// tb/tb_msrv32_decode_stage.sv - randomized self-checking bench for msrv32_decode_stage
module tb_msrv32_decode_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        instr_valid = 1'b0;
    logic        dec_ready = 1'b0;
    logic        trap = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [2:0]  lsb = 3'b0;

    always #5 clk = ~clk;

    logic        rdy_a, val_a, alu_src_a, iadder_src_a, lu_a, rf_a, csrw_a, muldiv_a, memwr_a, ill_a, misl_a, miss_a;
    logic [2:0]  wb_a, imm_a, csrop_a;
    logic [3:0]  aluop_a;
    logic [1:0]  lsz_a;
    logic [15:0] cnt_a;
    logic        rdy_b, val_b, alu_src_b, iadder_src_b, lu_b, rf_b, csrw_b, muldiv_b, memwr_b, ill_b, misl_b, miss_b;
    logic [2:0]  wb_b, imm_b, csrop_b;
    logic [3:0]  aluop_b;
    logic [1:0]  lsz_b;
    logic [1:0]  cnt_b;

    msrv32_decode_stage #(.XLEN(32), .SUPPORT_M(0), .CNT_WIDTH(16)) dut_a (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .flush_in(flush),
        .instr_valid_in(instr_valid), .instr_ready_out(rdy_a), .instr_in(instr), .iadder_lsb_in(lsb),
        .dec_valid_out(val_a), .dec_ready_in(dec_ready), .trap_taken_in(trap),
        .wb_mux_sel_out(wb_a), .imm_type_out(imm_a), .alu_opcode_out(aluop_a), .alu_src_out(alu_src_a),
        .iadder_src_out(iadder_src_a), .load_size_out(lsz_a), .load_unsigned_out(lu_a), .rf_wr_en_out(rf_a),
        .csr_wr_en_out(csrw_a), .csr_op_out(csrop_a), .is_muldiv_out(muldiv_a), .mem_wr_req_out(memwr_a),
        .illegal_instr_out(ill_a), .misaligned_load_out(misl_a), .misaligned_store_out(miss_a),
        .decode_count_out(cnt_a)
    );

    msrv32_decode_stage #(.XLEN(64), .SUPPORT_M(1), .CNT_WIDTH(2)) dut_b (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .flush_in(flush),
        .instr_valid_in(instr_valid), .instr_ready_out(rdy_b), .instr_in(instr), .iadder_lsb_in(lsb),
        .dec_valid_out(val_b), .dec_ready_in(dec_ready), .trap_taken_in(trap),
        .wb_mux_sel_out(wb_b), .imm_type_out(imm_b), .alu_opcode_out(aluop_b), .alu_src_out(alu_src_b),
        .iadder_src_out(iadder_src_b), .load_size_out(lsz_b), .load_unsigned_out(lu_b), .rf_wr_en_out(rf_b),
        .csr_wr_en_out(csrw_b), .csr_op_out(csrop_b), .is_muldiv_out(muldiv_b), .mem_wr_req_out(memwr_b),
        .illegal_instr_out(ill_b), .misaligned_load_out(misl_b), .misaligned_store_out(miss_b),
        .decode_count_out(cnt_b)
    );

    logic [26:0] obs_a, obs_b;
    assign obs_a = {val_a, rdy_a, wb_a, imm_a, aluop_a, alu_src_a, iadder_src_a, lsz_a, lu_a, rf_a,
                    csrw_a, csrop_a, muldiv_a, memwr_a, ill_a, misl_a, miss_a};
    assign obs_b = {val_b, rdy_b, wb_b, imm_b, aluop_b, alu_src_b, iadder_src_b, lsz_b, lu_b, rf_b,
                    csrw_b, csrop_b, muldiv_b, memwr_b, ill_b, misl_b, miss_b};

    typedef struct packed {
        logic [2:0] wb;
        logic [2:0] imm;
        logic [3:0] aluop;
        logic       alu_src;
        logic       iadder_src;
        logic [1:0] lsz;
        logic       lu;
        logic       rf;
        logic       csrw;
        logic [2:0] csrop;
        logic       muldiv;
        logic       store_ok;
        logic       ill;
        logic       mis_l;
        logic       mis_s;
    } bundle_t;

    bundle_t qa[$];
    bundle_t qb[$];
    int      mcnt_a = 0;
    int      mcnt_b = 0;
    int      total = 0;
    int      bad = 0;

    function automatic bundle_t ref_decode(input logic [31:0] w, input logic [2:0] addr, input int xlen, input bit m);
        bundle_t b;
        logic [2:0] f3;
        logic [6:0] f7;
        bit legal, mis;
        int nbytes;
        f3 = w[14:12];
        f7 = w[31:25];
        b = '0;
        legal = 1;
        nbytes = 1 << f3[1:0];
        mis = (int'(addr) % nbytes) != 0;
        case (w[6:0])
            7'h03: begin
                b.wb = 1; b.imm = 1; b.iadder_src = 1; b.lsz = f3[1:0]; b.lu = f3[2]; b.rf = 1; b.mis_l = mis;
                legal = !(f3 == 7 || (xlen == 32 && (f3 == 3 || f3 == 6)));
            end
            7'h23: begin
                b.imm = 2; b.iadder_src = 1; b.mis_s = mis;
                legal = f3 < 4 && !(xlen == 32 && f3 == 3);
                b.store_ok = legal && !mis;
            end
            7'h13: begin b.imm = 1; b.rf = 1; b.aluop[3] = (f3 == 5) ? w[30] : 1'b0; end
            7'h33: begin
                b.alu_src = 1; b.rf = 1;
                b.muldiv = m && f7 == 7'h01;
                b.aluop[3] = b.muldiv ? 1'b0 : w[30];
                legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (f7 == 7'h01 && m);
            end
            7'h37: begin b.wb = 2; b.imm = 4; b.rf = 1; end
            7'h17: begin b.wb = 3; b.imm = 4; b.rf = 1; end
            7'h6F: begin b.wb = 5; b.imm = 5; b.rf = 1; end
            7'h67: begin b.wb = 5; b.imm = 1; b.iadder_src = 1; b.rf = 1; end
            7'h63: begin b.imm = 3; b.alu_src = 1; legal = !(f3 == 2 || f3 == 3); end
            7'h73: begin
                b.wb = 4; b.imm = 6; b.csrop = f3; b.csrw = f3 != 0; b.rf = f3 != 0; legal = f3 != 4;
            end
            default: legal = 0;
        endcase
        b.aluop[2:0] = f3;
        b.ill = !legal;
        if (!legal) begin b.rf = 0; b.csrw = 0; end
        return b;
    endfunction

    function automatic logic [26:0] model_out(input bit sel_b);
        bundle_t h;
        int n;
        n = sel_b ? qb.size() : qa.size();
        h = '0;
        if (n == 0) return {1'b0, 1'b1, 25'b0};
        h = sel_b ? qb[0] : qa[0];
        return {1'b1, (n < 2), h.wb, h.imm, h.aluop, h.alu_src, h.iadder_src, h.lsz, h.lu, h.rf,
                h.csrw, h.csrop, h.muldiv, h.store_ok & ~trap, h.ill, h.mis_l, h.mis_s};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0: w[6:0] = 7'h03;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h17;  3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h33;  5: w[6:0] = 7'h37;  6: w[6:0] = 7'h63;  7: w[6:0] = 7'h67;
            8: w[6:0] = 7'h6F;  9: w[6:0] = 7'h73;  10: w[6:0] = 7'h0B;
            default: w[1:0] = 2'($urandom_range(0, 2));
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    task automatic tick();
        bit acc, xf;
        bundle_t da, db;
        acc = instr_valid && qa.size() < 2;
        xf  = qa.size() > 0 && dec_ready;
        da  = ref_decode(instr, lsb, 32, 0);
        db  = ref_decode(instr, lsb, 64, 1);
        @(posedge clk);
        if (rst) begin
            qa.delete(); qb.delete(); mcnt_a = 0; mcnt_b = 0;
        end else begin
            if (xf) begin
                if (mcnt_a < 65535) mcnt_a++;
                if (mcnt_b < 3) mcnt_b++;
            end
            if (flush) begin
                qa.delete(); qb.delete();
            end else begin
                if (xf) begin void'(qa.pop_front()); void'(qb.pop_front()); end
                if (acc) begin qa.push_back(da); qb.push_back(db); end
            end
        end
        #1;
    endtask

    task automatic drain();
        instr_valid = 0; dec_ready = 1;
        repeat (3) tick();
        dec_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick(); tick();
        total++;
        if (obs_a !== {1'b0, 1'b1, 25'b0} || cnt_a !== 16'd0) begin
            $display("FAIL reset_a: got %h/%0d exp %h/0", obs_a, cnt_a, {1'b0, 1'b1, 25'b0}); bad++;
        end
        total++;
        if (obs_b !== {1'b0, 1'b1, 25'b0} || cnt_b !== 2'd0) begin
            $display("FAIL reset_b: got %h/%0d exp %h/0", obs_b, cnt_b, {1'b0, 1'b1, 25'b0}); bad++;
        end
        rst = 0;
    endtask

    task automatic test_addi();
        instr = 32'h00500093; lsb = 0; instr_valid = 1; dec_ready = 1;
        tick();
        instr_valid = 0;
        total++;
        if ({val_a, wb_a, imm_a, aluop_a, rf_a} !== {1'b1, 3'b000, 3'b001, 4'b0000, 1'b1}) begin
            $display("FAIL addi_fields: got %b exp 1000001 00001", {val_a, wb_a, imm_a, aluop_a, rf_a}); bad++;
        end
        total++;
        if (obs_a !== model_out(0) || obs_b !== model_out(1)) begin
            $display("FAIL addi_model: got %h/%h exp %h/%h", obs_a, obs_b, model_out(0), model_out(1)); bad++;
        end
        tick();
        total++;
        if (cnt_a !== 16'd1 || cnt_b !== 2'd1 || val_a !== 1'b0) begin
            $display("FAIL addi_count: got %0d/%0d valid %b exp 1/1 valid 0", cnt_a, cnt_b, val_a); bad++;
        end
        dec_ready = 0;
    endtask

    task automatic test_backpressure();
        logic [2:0] seen[$];
        bit acc;
        dec_ready = 0; instr_valid = 1; lsb = 0;
        instr = 32'h00500093; tick();
        instr = 32'h00502093; tick();
        total++;
        if (rdy_a !== 1'b0 || rdy_b !== 1'b0) begin
            $display("FAIL bp_ready_low: got %b%b exp 00", rdy_a, rdy_b); bad++;
        end
        instr = 32'h00504093; tick();
        total++;
        if (obs_a !== model_out(0) || obs_b !== model_out(1)) begin
            $display("FAIL bp_hold: got %h/%h exp %h/%h", obs_a, obs_b, model_out(0), model_out(1)); bad++;
        end
        dec_ready = 1;
        for (int i = 0; i < 8 && seen.size() < 3; i++) begin
            if (val_a) seen.push_back(aluop_a[2:0]);
            acc = instr_valid && qa.size() < 2;
            tick();
            if (acc) instr_valid = 0;
            total++;
            if (obs_a !== model_out(0) || obs_b !== model_out(1)) begin
                $display("FAIL bp_drain: got %h/%h exp %h/%h", obs_a, obs_b, model_out(0), model_out(1)); bad++;
            end
        end
        total++;
        if (seen.size() != 3 || seen[0] !== 3'b000 || seen[1] !== 3'b010 || seen[2] !== 3'b100) begin
            $display("FAIL bp_order: got %0d entries exp 000,010,100", seen.size()); bad++;
        end
        instr_valid = 0;
        drain();
    endtask

    task automatic test_store();
        instr = 32'h0020A023; lsb = 3'b010; instr_valid = 1; dec_ready = 0;
        tick();
        instr_valid = 0;
        total++;
        if ({miss_a, memwr_a, miss_b, memwr_b} !== 4'b1010 || obs_a !== model_out(0)) begin
            $display("FAIL sw_misaligned: got %b exp 1010", {miss_a, memwr_a, miss_b, memwr_b}); bad++;
        end
        drain();
        lsb = 3'b000; instr_valid = 1;
        tick();
        instr_valid = 0;
        total++;
        if ({miss_a, memwr_a, miss_b, memwr_b} !== 4'b0101 || obs_b !== model_out(1)) begin
            $display("FAIL sw_aligned: got %b exp 0101", {miss_a, memwr_a, miss_b, memwr_b}); bad++;
        end
        trap = 1;
        #1;
        total++;
        if ({memwr_a, memwr_b} !== 2'b00 || obs_a !== model_out(0)) begin
            $display("FAIL sw_trap_mask: got %b exp 00", {memwr_a, memwr_b}); bad++;
        end
        trap = 0;
        drain();
    endtask

    task automatic test_ld();
        instr = 32'h0000B083; lsb = 3'b100; instr_valid = 1; dec_ready = 0;
        tick();
        instr_valid = 0;
        total++;
        if ({ill_a, rf_a} !== 2'b10) begin
            $display("FAIL ld_rv32: got ill/rf %b exp 10", {ill_a, rf_a}); bad++;
        end
        total++;
        if ({ill_b, misl_b, lsz_b} !== 4'b0111 || obs_b !== model_out(1)) begin
            $display("FAIL ld_rv64: got ill/mis/size %b exp 0111", {ill_b, misl_b, lsz_b}); bad++;
        end
        drain();
    endtask

    task automatic test_mul();
        instr = 32'h023100B3; lsb = 0; instr_valid = 1; dec_ready = 0;
        tick();
        instr_valid = 0;
        total++;
        if ({ill_a, muldiv_a, rf_a} !== 3'b100) begin
            $display("FAIL mul_no_m: got ill/muldiv/rf %b exp 100", {ill_a, muldiv_a, rf_a}); bad++;
        end
        total++;
        if ({ill_b, muldiv_b, aluop_b[3]} !== 3'b010 || obs_b !== model_out(1)) begin
            $display("FAIL mul_with_m: got ill/muldiv/alu3 %b exp 010", {ill_b, muldiv_b, aluop_b[3]}); bad++;
        end
        drain();
    endtask

    task automatic test_flush();
        int c0;
        dec_ready = 0; instr_valid = 1; lsb = 0;
        instr = 32'h00500093; tick();
        instr = 32'h00502093; tick();
        c0 = mcnt_a;
        flush = 1; instr = 32'h00504093;
        tick();
        flush = 0; instr_valid = 0;
        total++;
        if (val_a !== 1'b0 || rdy_a !== 1'b1 || val_b !== 1'b0 || cnt_a !== 16'(c0)) begin
            $display("FAIL flush_two: got valid %b ready %b cnt %0d exp valid 0 ready 1 cnt %0d", val_a, rdy_a, cnt_a, c0); bad++;
        end
        tick();
        total++;
        if (obs_a !== model_out(0) || obs_b !== model_out(1)) begin
            $display("FAIL flush_after: got %h/%h exp %h/%h", obs_a, obs_b, model_out(0), model_out(1)); bad++;
        end
    endtask

    task automatic test_saturate();
        rst = 1; tick(); rst = 0;
        dec_ready = 1; instr_valid = 1;
        for (int i = 0; i < 5; i++) begin
            instr = rand_instr(); lsb = 3'($urandom);
            tick();
        end
        instr_valid = 0;
        tick();
        total++;
        if (cnt_a !== 16'd5 || cnt_b !== 2'd3) begin
            $display("FAIL count_saturate: got %0d/%0d exp 5/3", cnt_a, cnt_b); bad++;
        end
        dec_ready = 0;
    endtask

    task automatic test_back_to_back();
        instr_valid = 1; dec_ready = 1;
        for (int i = 0; i < 20; i++) begin
            instr = rand_instr(); lsb = 3'($urandom);
            tick();
            total++;
            if (val_a !== 1'b1 || rdy_a !== 1'b1 || obs_a !== model_out(0) || obs_b !== model_out(1)) begin
                $display("FAIL back_to_back: got %h/%h exp %h/%h", obs_a, obs_b, model_out(0), model_out(1)); bad++;
            end
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            instr       = rand_instr();
            lsb         = 3'($urandom);
            instr_valid = ($urandom_range(0, 3) != 0);
            dec_ready   = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            trap        = ($urandom_range(0, 7) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            tick();
            total++;
            if (obs_a !== model_out(0) || cnt_a !== 16'(mcnt_a)) begin
                $display("FAIL random_a: got %h/%0d exp %h/%0d", obs_a, cnt_a, model_out(0), mcnt_a); bad++;
            end
            total++;
            if (obs_b !== model_out(1) || cnt_b !== 2'(mcnt_b)) begin
                $display("FAIL random_b: got %h/%0d exp %h/%0d", obs_b, cnt_b, model_out(1), mcnt_b); bad++;
            end
        end
        rst = 0; flush = 0; trap = 0; instr_valid = 0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_backpressure();
        test_store();
        test_ld();
        test_mul();
        test_flush();
        test_saturate();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/msrv32_decode_stage.md
Name: msrv32_decode_stage

Overview:
- Pipelined, parametrised instruction decoder. Sits between fetch and the register-file/execute stage.
- Decodes RV32I/RV64I base encodings, plus optional M-extension encodings, into a registered control bundle.
- Full valid/ready handshake with a 2-entry skid buffer, so instr_ready_out is a register output.
- Also provides flush support, alignment checking for XLEN-wide accesses, and a saturating count of decoded instructions.

Parameters:
- XLEN, 32: 32 or 64. Selects legality of LD/SD/LWU and the doubleword alignment check.
- SUPPORT_M, 0: 1 makes OP with funct7=0000001 legal and raises is_muldiv_out.
- CNT_WIDTH, 16: width of the decoded-instruction counter.

Ports:
- ms_riscv32_mp_clk_in  in  1  clock, rising edge.
- ms_riscv32_mp_rst_in  in  1  synchronous, active-high reset.
- flush_in  in  1  discards all held entries this cycle.
- instr_valid_in  in  1  upstream valid.
- instr_ready_out  out  1  upstream ready (registered).
- instr_in  in  32  instruction word.
- iadder_lsb_in  in  3  effective address [2:0], valid with instr_in.
- dec_valid_out  out  1  output bundle valid.
- dec_ready_in  in  1  downstream ready.
- trap_taken_in  in  1  combinationally masks mem_wr_req_out.
- wb_mux_sel_out  out  3  writeback select.
- imm_type_out  out  3  immediate format.
- alu_opcode_out  out  4  {funct7_5 qualified, funct3}.
- alu_src_out  out  1  1 = rs2, 0 = immediate.
- iadder_src_out  out  1  1 = rs1 (load/store/jalr), 0 = PC.
- load_size_out  out  2  funct3[1:0] for loads.
- load_unsigned_out  out  1  funct3[2] for loads.
- rf_wr_en_out  out  1  register-file write enable.
- csr_wr_en_out  out  1  CSR write enable.
- csr_op_out  out  3  funct3.
- is_muldiv_out  out  1  M-extension op.
- mem_wr_req_out  out  1  store request.
- illegal_instr_out  out  1  illegal instruction.
- misaligned_load_out  out  1  misaligned load.
- misaligned_store_out  out  1  misaligned store.
- decode_count_out  out  CNT_WIDTH  saturating count of accepted output transfers.

Behaviour:
- Reset (synchronous, ms_riscv32_mp_rst_in=1 at a rising edge): both buffer entries become invalid, instr_ready_out=1, decode_count_out=0. All bundle outputs read 0 while dec_valid_out=0. Reset mid-transfer drops the entries in flight.
- Decode runs combinationally on instr_in. The bundle is registered on acceptance (instr_valid_in & instr_ready_out), so latency is 1 cycle from acceptance to dec_valid_out.
- Buffer states:
  - EMPTY: dec_valid_out=0, ready=1.
  - ONE: output register valid, ready=1.
  - TWO: output register and skid entry both valid, ready=0.
- Buffer transitions:
  - EMPTY→ONE on accept.
  - ONE→ONE on accept together with downstream transfer (dec_valid_out & dec_ready_in).
  - ONE→TWO on accept without downstream transfer; the new bundle goes to the skid entry.
  - ONE→EMPTY on downstream transfer without accept.
  - TWO→ONE on downstream transfer; the skid entry moves to the output register.
  - Order is preserved; no bubble when both sides are continuously ready.
- flush_in=1: next state EMPTY and any same-cycle input is not captured. Takes priority over accept; reset takes priority over flush.
- wb_mux_sel_out encoding:
  - 000: OP/OP-IMM (ALU).
  - 001: load.
  - 010: LUI.
  - 011: AUIPC.
  - 100: CSR.
  - 101: JAL/JALR (PC+4).
- imm_type_out encoding: 000 R, 001 I (OP-IMM/load/JALR), 010 S, 011 B, 100 U, 101 J, 110 CSR.
- alu_opcode_out[2:0] = funct3. alu_opcode_out[3] = instr[30] for OP (not muldiv), and for OP-IMM with funct3=101; otherwise 0.
- rf_wr_en_out = 1 for OP, OP-IMM, load, JAL, JALR, LUI, AUIPC, and CSR instructions with rd≠0 semantics ignored. It is forced to 0 when the instruction is illegal.
- csr_wr_en_out = 1 for SYSTEM with funct3≠000. It is forced to 0 when the instruction is illegal.
- Illegal when any of:
  - opcode[1:0]≠11, or unknown opcode;
  - load funct3=111; load funct3 ∈ {011,110} with XLEN=32;
  - store funct3 ≥ 100; store funct3=011 with XLEN=32;
  - branch funct3 ∈ {010,011};
  - OP funct7 ∉ {0000000, 0100000 (funct3 000/101 only), 0000001 (SUPPORT_M=1 only)};
  - SYSTEM funct3=100.
- Misalignment is registered with the bundle and checked for loads/stores only:
  - half: lsb[0]≠0;
  - word: lsb[1:0]≠00;
  - double: lsb[2:0]≠000.
- mem_wr_req_out = registered (store & legal & aligned) & dec_valid_out & ~trap_taken_in.
- decode_count_out increments on each downstream transfer and holds at all-ones (no wrap).

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) with dec_ready_in=1 → next cycle dec_valid_out=1, wb=000, imm=001, alu_opcode=0000, rf_wr_en=1, count=1.
- Hold dec_ready_in=0 and offer 3 back-to-back instructions → first two captured, instr_ready_out=0 on the cycle after the second. Raise ready → outputs appear in order; the third is accepted once ready returns.
- SW with iadder_lsb_in=010, trap_taken_in=0 → misaligned_store_out=1, mem_wr_req_out=0. With lsb=000 → mem_wr_req_out=1; same with trap_taken_in=1 → 0.
- XLEN=32: LD (funct3=011) → illegal_instr_out=1, rf_wr_en_out=0. XLEN=64, LD with lsb=100 → legal, misaligned_load_out=1, load_size_out=11.
- MUL (funct7=0000001): SUPPORT_M=0 → illegal=1. SUPPORT_M=1 → is_muldiv_out=1, alu_opcode[3]=0.
- With state TWO, assert flush_in together with instr_valid_in → next cycle dec_valid_out=0, instr_ready_out=1, count unchanged. Count saturates at 2^CNT_WIDTH−1 with CNT_WIDTH=2 after 5 transfers.
